hazard_ctrl_gen: RTL and testbench

Parametrised hazard and forwarding controller for the pipelined MIPS core, generalised from the fixed E/M/W single-issue unit. It replaces the per-stage hard-coded compare chains with a priority search over `NFWD` producer stages, so the nearest in-flight writer always shadows older ones. It also owns a cycle-accurate multiply/divide busy timer that interlocks D-stage HI/LO instructions. It sits beside the pipeline registers, takes register addresses and T_new/T_use values from them, and drives stall, bubble and forwarding-mux selects.

---
 rtl/hazard_ctrl_gen_pkg.sv | 31 +++
 rtl/hz_mdu_timer.sv | 38 +++
 rtl/hazard_ctrl_gen.sv | 131 +++++++++++++
 tb/tb_hazard_ctrl_gen.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_gen_pkg.sv
// Shared definitions for the hazard/forwarding controller: forward-select
// codes, stage indices, default multiply/divide latencies, the T-width
// default and the MDU timer state type.
package hazard_ctrl_gen_pkg;

  // Select codes as seen by a D-stage consumer (0 = register file)
  localparam int FWD_RF = 0;
  localparam int FWD_E  = 1;
  localparam int FWD_M  = 2;
  localparam int FWD_W  = 3;

  // Pipeline stage indices (producer index and consumer search start)
  localparam int STG_D = 0;
  localparam int STG_E = 1;
  localparam int STG_M = 2;

  // Default multiply/divide busy lengths and T_new/T_use width
  localparam int DEF_MULT_CYC = 5;
  localparam int DEF_DIV_CYC  = 10;
  localparam int DEF_TW       = 2;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hz_mdu_timer.sv
// Multiply/divide busy timer: a down-counter loaded with the operation
// latency when an MDU op leaves E, busy while the count is nonzero.
// A start while busy reloads and restarts the count.
module hz_mdu_timer
  import hazard_ctrl_gen_pkg::*;
#(
  parameter int MULT_CYC = DEF_MULT_CYC,
  parameter int DIV_CYC  = DEF_DIV_CYC
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start_i,
  input  logic is_div_i,
  output logic busy_o
);

  localparam int CW = $clog2(max2(MULT_CYC, DIV_CYC) + 1);

  md_state_e       state_q;
  logic [CW-1:0]   cnt_q;

  // Load on start, count down while busy, fall to IDLE when the last cycle expires
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else if (start_i) begin
      state_q <= MD_BUSY;
      cnt_q   <= is_div_i ? CW'(DIV_CYC) : CW'(MULT_CYC);
    end else if (state_q == MD_BUSY) begin
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) state_q <= MD_IDLE;
    end
  end

  assign busy_o = (state_q == MD_BUSY);

endmodule

// File: rtl/hazard_ctrl_gen.sv
// Parametrised hazard and forwarding controller for the pipelined MIPS core.
// Each consumer searches the in-flight producers nearest-first; the first
// address match governs, so a younger writer always shadows older ones.
// Optional feature: define HAZ_STALL_CNT_EN to add a saturating stall counter.
module hazard_ctrl_gen
  import hazard_ctrl_gen_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int TW       = DEF_TW,
  parameter int NFWD     = 3,
  parameter int SW       = $clog2(NFWD + 1),
  parameter int MULT_CYC = DEF_MULT_CYC,
  parameter int DIV_CYC  = DEF_DIV_CYC,
  parameter int CNT_W    = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NFWD-1:0]        prod_we,
  input  logic [NFWD*REG_AW-1:0] prod_wr,
  input  logic [NFWD*TW-1:0]     prod_tnew,
  input  logic [REG_AW-1:0]      rs_D,
  input  logic [REG_AW-1:0]      rt_D,
  input  logic [REG_AW-1:0]      rs_E,
  input  logic [REG_AW-1:0]      rt_E,
  input  logic [REG_AW-1:0]      rt_M,
  input  logic [TW-1:0]          rs_tuse_D,
  input  logic [TW-1:0]          rt_tuse_D,
  input  logic                   md_start_E,
  input  logic                   md_is_div_E,
  input  logic                   md_use_D,
  output logic                   stall,
  output logic [SW-1:0]          fwd_rs_D,
  output logic [SW-1:0]          fwd_rt_D,
  output logic [SW-1:0]          fwd_rs_E,
  output logic [SW-1:0]          fwd_rt_E,
  output logic [SW-1:0]          fwd_rt_M,
  output logic                   md_busy,
  output logic [CNT_W-1:0]       stall_cnt
);

  localparam int NCONS = 5;

  // Consumers 0..4: rs_D, rt_D, rs_E, rt_E, rt_M
  logic [REG_AW-1:0] cons_addr [NCONS];
  assign cons_addr[0] = rs_D;
  assign cons_addr[1] = rt_D;
  assign cons_addr[2] = rs_E;
  assign cons_addr[3] = rt_E;
  assign cons_addr[4] = rt_M;

  for (genvar c = 0; c < NCONS; c++) begin : g_cons
    // Consumer stage: D for 0/1, E for 2/3, M for 4; only producers at or beyond it are visible
    localparam int K = (c < 2) ? STG_D : ((c < 4) ? STG_E : STG_M);

    logic          hit;
    logic [SW-1:0] idx;
    logic [TW-1:0] tn;
    logic [SW-1:0] code;

    // Priority search: scan oldest to youngest so the lowest matching index wins
    always_comb begin
      hit = 1'b0;
      idx = '0;
      tn  = '0;
      for (int i = NFWD - 1; i >= K; i--) begin
        if (prod_we[i] && (prod_wr[i*REG_AW +: REG_AW] == cons_addr[c]) &&
            (cons_addr[c] != '0)) begin
          hit = 1'b1;
          idx = SW'(i);
          tn  = prod_tnew[i*TW +: TW];
        end
      end
    end

    // Forward only from a ready governing producer; D codes are offset past the regfile code
    always_comb begin
      code = '0;
      if (hit && (tn == '0)) code = (K == STG_D) ? (idx + SW'(1)) : idx;
    end
  end

  assign fwd_rs_D = g_cons[0].code;
  assign fwd_rt_D = g_cons[1].code;
  assign fwd_rs_E = g_cons[2].code;
  assign fwd_rt_E = g_cons[3].code;
  assign fwd_rt_M = g_cons[4].code;

  logic data_stall;
  logic md_stall;

  // A D source stalls when its governing producer delivers later than it is needed
  always_comb begin
    data_stall = (g_cons[0].hit && (g_cons[0].tn > rs_tuse_D)) ||
                 (g_cons[1].hit && (g_cons[1].tn > rt_tuse_D));
    md_stall   = md_use_D && (md_busy || md_start_E);
    stall      = data_stall || md_stall;
  end

  hz_mdu_timer #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC)
  ) u_mdu_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .start_i  (md_start_E),
    .is_div_i (md_is_div_E),
    .busy_o   (md_busy)
  );

`ifdef HAZ_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;

  // Saturating increment on stalled cycles
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  // Stall counter register, cleared by reset
  always_ff @(posedge clk) begin
    if (!reset_n) stall_cnt_q <= '0;
    else          stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_gen.sv
// Directed bench for hazard_ctrl_gen (REG_AW=5, TW=2, NFWD=3, MULT=5, DIV=10, CNT_W=4).
module tb_hazard_ctrl_gen;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  prod_we;
  logic [14:0] prod_wr;
  logic [5:0]  prod_tnew;
  logic [4:0]  rs_D, rt_D, rs_E, rt_E, rt_M;
  logic [1:0]  rs_tuse_D, rt_tuse_D;
  logic        md_start_E, md_is_div_E, md_use_D;
  logic        stall;
  logic [1:0]  fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M;
  logic        md_busy;
  logic [3:0]  stall_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hazard_ctrl_gen #(.CNT_W(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .prod_we(prod_we), .prod_wr(prod_wr), .prod_tnew(prod_tnew),
    .rs_D(rs_D), .rt_D(rt_D), .rs_E(rs_E), .rt_E(rt_E), .rt_M(rt_M),
    .rs_tuse_D(rs_tuse_D), .rt_tuse_D(rt_tuse_D),
    .md_start_E(md_start_E), .md_is_div_E(md_is_div_E), .md_use_D(md_use_D),
    .stall(stall),
    .fwd_rs_D(fwd_rs_D), .fwd_rt_D(fwd_rt_D), .fwd_rs_E(fwd_rs_E),
    .fwd_rt_E(fwd_rt_E), .fwd_rt_M(fwd_rt_M),
    .md_busy(md_busy), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected counter value: only present when the counter is built in
  function automatic int cexp(input int n);
`ifdef HAZ_STALL_CNT_EN
    return n;
`else
    return 0;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setp(input int i, input logic we, input logic [4:0] wr, input logic [1:0] tn);
    prod_we[i]          = we;
    prod_wr[i*5 +: 5]   = wr;
    prod_tnew[i*2 +: 2] = tn;
  endtask

  task automatic clear_all();
    prod_we = '0; prod_wr = '0; prod_tnew = '0;
    rs_D = '0; rt_D = '0; rs_E = '0; rt_E = '0; rt_M = '0;
    rs_tuse_D = '0; rt_tuse_D = '0;
    md_start_E = 1'b0; md_is_div_E = 1'b0; md_use_D = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    clear_all();
    step(); step();
    chk("rst_busy", md_busy, 0);
    chk("rst_cnt", stall_cnt, 0);
    chk("rst_stall", stall, 0);
    chk("rst_fwd_rs_D", fwd_rs_D, 0);

    // Combinational checks held in reset: outputs still follow inputs
    // Load-use: lw $5 in E, tnew 2, consumer tuse 1
    setp(0, 1'b1, 5'd5, 2'd2); rs_D = 5'd5; rs_tuse_D = 2'd1; #1;
    chk("lu_stall", stall, 1);
    chk("lu_fwd0", fwd_rs_D, 0);
    // Same load now in M with tnew 1
    setp(0, 1'b0, 5'd0, 2'd0); setp(1, 1'b1, 5'd5, 2'd1); #1;
    chk("lu_m_stall", stall, 0);
    chk("lu_m_fwd", fwd_rs_D, 0);
    // Result ready in M
    setp(1, 1'b1, 5'd5, 2'd0); rs_E = 5'd5; rt_M = 5'd5; #1;
    chk("lu_ready_fwd", fwd_rs_D, 2);
    chk("lu_rs_E_m", fwd_rs_E, 1);
    chk("lu_rt_M_none", fwd_rt_M, 0);
    setp(2, 1'b1, 5'd5, 2'd0); #1;
    chk("rs_E_m_shadows_w", fwd_rs_E, 1);
    chk("rt_M_w", fwd_rt_M, 2);

    // Shadowing: E writes $8 not ready, W writes $8 ready
    clear_all();
    setp(0, 1'b1, 5'd8, 2'd1); setp(2, 1'b1, 5'd8, 2'd0);
    rt_D = 5'd8; rt_tuse_D = 2'd2; rt_E = 5'd8; #1;
    chk("sh_stall", stall, 0);
    chk("sh_fwd_rt_D", fwd_rt_D, 0);
    chk("sh_fwd_rt_E", fwd_rt_E, 2);
    rt_tuse_D = 2'd0; #1;
    chk("sh_stall_tuse0", stall, 1);

    // $0 guard: everyone writes $0, ready
    clear_all();
    setp(0, 1'b1, 5'd0, 2'd0); setp(1, 1'b1, 5'd0, 2'd0); setp(2, 1'b1, 5'd0, 2'd0); #1;
    chk("r0_fwd_rs_E", fwd_rs_E, 0);
    chk("r0_fwd_rs_D", fwd_rs_D, 0);
    chk("r0_stall", stall, 0);

    // Write-enable gates the match
    clear_all();
    setp(0, 1'b0, 5'd9, 2'd0); rs_D = 5'd9; #1;
    chk("we0_fwd", fwd_rs_D, 0);
    setp(0, 1'b1, 5'd9, 2'd0); #1;
    chk("we1_fwd_e", fwd_rs_D, 1);

    // MDU interlock from md_start_E alone
    clear_all();
    md_use_D = 1'b1; md_start_E = 1'b1; #1;
    chk("md_start_stall", stall, 1);
    md_use_D = 1'b0; #1;
    chk("md_nouse_stall", stall, 0);
    clear_all();
    step();
    chk("rst_hold_busy", md_busy, 0);
    chk("rst_hold_cnt", stall_cnt, 0);

    // Divide interlock with mflo held in D
    reset_n = 1'b1;
    step();
    md_start_E = 1'b1; md_is_div_E = 1'b1; md_use_D = 1'b1; #1;
    chk("div_pre_busy", md_busy, 0);
    chk("div_pre_stall", stall, 1);
    step();
    md_start_E = 1'b0; md_is_div_E = 1'b0; #1;
    for (int k = 1; k <= 10; k++) begin
      chk($sformatf("div_busy_%0d", k), md_busy, 1);
      chk($sformatf("div_stall_%0d", k), stall, 1);
      step();
    end
    chk("div_done_busy", md_busy, 0);
    chk("div_done_stall", stall, 0);
    chk("div_cnt", stall_cnt, cexp(11));

    // Reset in the middle of a multiply
    md_use_D = 1'b0;
    md_start_E = 1'b1; step();
    md_start_E = 1'b0;
    step(); step(); step();
    chk("mul_busy_t3", md_busy, 1);
    reset_n = 1'b0;
    step();
    chk("mul_rst_busy", md_busy, 0);
    chk("mul_rst_cnt", stall_cnt, 0);
    md_use_D = 1'b1;
    setp(0, 1'b1, 5'd5, 2'd2); rs_D = 5'd5; rs_tuse_D = 2'd0; #1;
    chk("mul_rst_data_stall", stall, 1);
    clear_all(); md_use_D = 1'b1; #1;
    chk("mul_rst_no_stall", stall, 0);
    step();
    reset_n = 1'b1;

    // Saturation: back-to-back starts with an MDU consumer in D
    md_start_E = 1'b1;
    for (int k = 0; k < 14; k++) step();
    chk("sat_cnt14", stall_cnt, cexp(14));
    for (int k = 0; k < 6; k++) step();
    chk("sat_cnt15", stall_cnt, cexp(15));
    md_start_E = 1'b0;
    for (int k = 0; k < 4; k++) step();
    chk("mul_reload_busy", md_busy, 1);
    step();
    chk("mul_reload_idle", md_busy, 0);
    chk("sat_hold", stall_cnt, cexp(15));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
